mii_64b66b_encoder: RTL

//  BASE-R PCS transmit encoder, directly downstream of mac_mii_top.

---
 rtl/mii_64b66b_encoder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mii_64b66b_encoder.sv
// BASE-R PCS transmit encoder: turns one 64-bit MII beat plus lane control flags into
// an unscrambled 66-bit block, policed by the TX block-sequence state machine.
module mii_64b66b_encoder #(
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic [63:0]              i_mii_data,
  input  logic [7:0]               i_mii_ctrl,
  output logic [65:0]              o_block,
  output logic                     o_valid,
  output logic [ERR_CNT_WIDTH-1:0] o_err_count
);

  localparam logic [65:0] EBLOCK = {{8{7'h1E}}, 8'h1E, 2'b10};

  typedef enum logic [2:0] {TX_INIT, TX_C, TX_D, TX_T, TX_E} tx_state_e;
  typedef enum logic [2:0] {BT_C, BT_S, BT_D, BT_T, BT_E} beat_e;

  function automatic logic [6:0] code7(input logic [7:0] b);
    return (b == 8'hFE) ? 7'h1E : 7'h00;
  endfunction

  function automatic logic [7:0] term_type(input int k);
    case (k)
      0:       return 8'h87;
      1:       return 8'h99;
      2:       return 8'hAA;
      3:       return 8'hB4;
      4:       return 8'hCC;
      5:       return 8'hD2;
      6:       return 8'hE1;
      default: return 8'hFF;
    endcase
  endfunction

  // Data lane j lands at payload bit 8j and control lane j at 7j; the gap between is the pad.
  function automatic logic [65:0] term_block(input logic [63:0] d, input logic [7:0] hit);
    logic [55:0] p;
    logic [7:0]  t;
    p = 56'h0;
    t = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (hit[k]) begin
        t = term_type(k);
        for (int j = 0; j < 8; j++) begin
          if (j < k) p[8*j +: 8] = d[8*j +: 8];
          else if (j > k) p[7*j +: 7] = code7(d[8*j +: 8]);
        end
      end
    end
    return {p, t, 2'b10};
  endfunction

  tx_state_e               state_q, state_d;
  logic [65:0]             block_q, block_d;
  logic                    valid_q;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic [7:0]  lane_ie_s;
  logic [7:0]  term_hit_s;
  beat_e       beat_s;
  logic [65:0] enc_s;

  for (genvar k = 0; k < 8; k++) begin : g_lane
    localparam logic [7:0] MASK = 8'hFF << k;
    localparam logic [7:0] TAIL = 8'hFE << k;
    assign lane_ie_s[k]  = (i_mii_data[8*k +: 8] == 8'h07) || (i_mii_data[8*k +: 8] == 8'hFE);
    assign term_hit_s[k] = (i_mii_ctrl == MASK) && (i_mii_data[8*k +: 8] == 8'hFD)
                           && (&(lane_ie_s | ~TAIL));
  end

  always_comb begin
    beat_s = BT_E;
    enc_s  = EBLOCK;
    if (i_mii_ctrl == 8'h00) begin
      beat_s = BT_D;
      enc_s  = {i_mii_data, 2'b01};
    end else if ((i_mii_ctrl == 8'hFF) && (&lane_ie_s)) begin
      beat_s      = BT_C;
      enc_s[9:0]  = {8'h1E, 2'b10};
      for (int j = 0; j < 8; j++) enc_s[10 + 7*j +: 7] = code7(i_mii_data[8*j +: 8]);
    end else if ((i_mii_ctrl == 8'h01) && (i_mii_data[7:0] == 8'hFB)) begin
      beat_s = BT_S;
      enc_s  = {i_mii_data[63:8], 8'h78, 2'b10};
    end else if (|term_hit_s) begin
      beat_s = BT_T;
      enc_s  = term_block(i_mii_data, term_hit_s);
    end else begin
      beat_s = BT_E;
      enc_s  = EBLOCK;
    end
  end

  always_comb begin
    state_d = TX_E;
    case (state_q)
      TX_INIT, TX_C, TX_T: begin
        if (beat_s == BT_C)      state_d = TX_C;
        else if (beat_s == BT_S) state_d = TX_D;
        else                     state_d = TX_E;
      end
      TX_D: begin
        if (beat_s == BT_D)      state_d = TX_D;
        else if (beat_s == BT_T) state_d = TX_T;
        else                     state_d = TX_E;
      end
      TX_E: begin
        if (beat_s == BT_D)      state_d = TX_D;
        else if (beat_s == BT_T) state_d = TX_T;
        else if (beat_s == BT_C) state_d = TX_C;
        else                     state_d = TX_E;
      end
      default: state_d = TX_E;
    endcase
    block_d   = (state_d == TX_E) ? EBLOCK : enc_s;
    err_cnt_d = err_cnt_q;
    if ((state_d == TX_E) && (err_cnt_q != {ERR_CNT_WIDTH{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= TX_INIT;
      block_q   <= 66'h0;
      valid_q   <= 1'b0;
      err_cnt_q <= '0;
    end else if (i_valid) begin
      state_q   <= state_d;
      block_q   <= block_d;
      valid_q   <= 1'b1;
      err_cnt_q <= err_cnt_d;
    end else begin
      valid_q   <= 1'b0;
    end
  end

  assign o_block     = block_q;
  assign o_valid     = valid_q;
  assign o_err_count = err_cnt_q;

endmodule
